noc_layer_sched: RTL and testbench

// Clocked scheduler that sequences one SNN inference over the NoC: issues weight-load,

---
 rtl/noc_layer_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_noc_layer_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_layer_sched.sv
// noc_layer_sched: sequences one SNN inference over the NoC.
// Issues LOAD_W / LOAD_I / TS_GO command packets to WMEM, IMEM and OMEM and waits for the
// matching completion packets. It loops NUM_TS timesteps per layer and NUM_LAYERS layers.
// Optional feature: define SCHED_TIMEOUT_EN to add a wait-state timeout with a sticky err flag.
// Packet layout: [32:28] dest, [27:23] src, [22:20] opcode, [19:12] layer, [11:0] ts.

module noc_layer_sched #(
  parameter int unsigned WIDTH_PACKAGE = 33,
  parameter int unsigned NUM_TS        = 10,
  parameter int unsigned NUM_LAYERS    = 2,
  parameter logic [4:0]  SCHED_LOC     = 5'b011_10,
  parameter logic [4:0]  WMEM_LOC      = 5'b000_10,
  parameter logic [4:0]  IMEM_LOC      = 5'b001_10,
  parameter logic [4:0]  OMEM_LOC      = 5'b010_10,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [WIDTH_PACKAGE-1:0] cmd_data,
  input  logic                     resp_valid,
  output logic                     resp_ready,
  input  logic [WIDTH_PACKAGE-1:0] resp_data,
  output logic [7:0]               cur_layer,
  output logic [11:0]              cur_ts
);

  localparam logic [2:0] OpLoadW  = 3'd0;
  localparam logic [2:0] OpLoadI  = 3'd1;
  localparam logic [2:0] OpTsGo   = 3'd2;
  localparam logic [2:0] OpWDone  = 3'd4;
  localparam logic [2:0] OpIDone  = 3'd5;
  localparam logic [2:0] OpTsDone = 3'd6;

  localparam logic [11:0] LastTs    = 12'(NUM_TS - 1);
  localparam logic [7:0]  LastLayer = 8'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSendW,
    StWaitW,
    StSendI,
    StWaitI,
    StSendGo,
    StWaitTs,
    StFinish
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               layer_q, layer_d;
  logic [11:0]              ts_q, ts_d;
  logic [WIDTH_PACKAGE-1:0] cmd_data_q, cmd_data_d;

  // Response field decode; dest/src are not needed to qualify a completion.
  logic [2:0]  resp_op;
  logic [7:0]  resp_layer;
  logic [11:0] resp_ts;
  logic        unused_resp_route;

  assign resp_op           = resp_data[22:20];
  assign resp_layer        = resp_data[19:12];
  assign resp_ts           = resp_data[11:0];
  assign unused_resp_route = ^resp_data[WIDTH_PACKAGE-1:23];

  logic match_w, match_i, match_ts, in_wait, wait_match;

  // Weight completions are per layer, so only the layer field is compared for W_DONE.
  assign match_w  = resp_valid && (resp_op == OpWDone) && (resp_layer == layer_q);
  assign match_i  = resp_valid && (resp_op == OpIDone) && (resp_layer == layer_q) &&
                    (resp_ts == ts_q);
  assign match_ts = resp_valid && (resp_op == OpTsDone) && (resp_layer == layer_q) &&
                    (resp_ts == ts_q);

  assign in_wait    = (state_q == StWaitW) || (state_q == StWaitI) || (state_q == StWaitTs);
  assign wait_match = ((state_q == StWaitW) && match_w) ||
                      ((state_q == StWaitI) && match_i) ||
                      ((state_q == StWaitTs) && match_ts);

  function automatic logic [WIDTH_PACKAGE-1:0] mk_pkt(input logic [4:0]  dest,
                                                      input logic [2:0]  op,
                                                      input logic [7:0]  layer,
                                                      input logic [11:0] ts);
    return {dest, SCHED_LOC, op, layer, ts};
  endfunction

`ifdef SCHED_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic        timed_out;

  assign timed_out = in_wait && !wait_match && (wait_cnt_q == 16'(TIMEOUT - 1));
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
`endif

  // Next-state, loop counters and command packet composition.
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    ts_d       = ts_q;
    cmd_data_d = cmd_data_q;
`ifdef SCHED_TIMEOUT_EN
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          layer_d    = 8'd0;
          ts_d       = 12'd0;
          cmd_data_d = mk_pkt(WMEM_LOC, OpLoadW, 8'd0, 12'd0);
          state_d    = StSendW;
        end
      end
      StSendW: begin
        if (cmd_ready) state_d = StWaitW;
      end
      StWaitW: begin
        if (match_w) begin
          cmd_data_d = mk_pkt(IMEM_LOC, OpLoadI, layer_q, ts_q);
          state_d    = StSendI;
        end
      end
      StSendI: begin
        if (cmd_ready) state_d = StWaitI;
      end
      StWaitI: begin
        if (match_i) begin
          cmd_data_d = mk_pkt(OMEM_LOC, OpTsGo, layer_q, ts_q);
          state_d    = StSendGo;
        end
      end
      StSendGo: begin
        if (cmd_ready) state_d = StWaitTs;
      end
      StWaitTs: begin
        if (match_ts) begin
          if (ts_q != LastTs) begin
            ts_d       = ts_q + 12'd1;
            cmd_data_d = mk_pkt(IMEM_LOC, OpLoadI, layer_q, ts_q + 12'd1);
            state_d    = StSendI;
          end else if (layer_q != LastLayer) begin
            layer_d    = layer_q + 8'd1;
            ts_d       = 12'd0;
            cmd_data_d = mk_pkt(WMEM_LOC, OpLoadW, layer_q + 8'd1, 12'd0);
            state_d    = StSendW;
          end else begin
            // Layer/timestep indices hold so the host can read the final position.
            state_d = StFinish;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
`ifdef SCHED_TIMEOUT_EN
    // Every wait state is entered from a send state, so clearing there restarts the count.
    if (in_wait) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_d = 16'd0;
    end
    if ((state_q == StIdle) && start) err_d = 1'b0;
    // A match in the limit cycle has already advanced state_d and is left untouched.
    if (timed_out) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      layer_q    <= 8'd0;
      ts_q       <= 12'd0;
      cmd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      ts_q       <= ts_d;
      cmd_data_q <= cmd_data_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  // Wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Status and handshake outputs are decoded straight from the registered state.
  always_comb begin
    busy      = (state_q != StIdle) && (state_q != StFinish);
    done      = (state_q == StFinish);
    cmd_valid = (state_q == StSendW) || (state_q == StSendI) || (state_q == StSendGo);
  end

  assign resp_ready = ~rst;
  assign cmd_data   = cmd_data_q;
  assign cur_layer  = layer_q;
  assign cur_ts     = ts_q;

endmodule

// File: tb/tb_noc_layer_sched.sv
// Directed bench for noc_layer_sched with NUM_TS=2, NUM_LAYERS=2, TIMEOUT=8.
// Timeout checks are active when SCHED_TIMEOUT_EN is defined.

module tb_noc_layer_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [32:0] cmd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [32:0] resp_data;
  logic [7:0]  cur_layer;
  logic [11:0] cur_ts;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;

  localparam logic [4:0] Wmem  = 5'b000_10;
  localparam logic [4:0] Imem  = 5'b001_10;
  localparam logic [4:0] Omem  = 5'b010_10;
  localparam logic [4:0] Sched = 5'b011_10;

  noc_layer_sched #(
    .WIDTH_PACKAGE(33),
    .NUM_TS       (2),
    .NUM_LAYERS   (2),
    .SCHED_LOC    (Sched),
    .WMEM_LOC     (Wmem),
    .IMEM_LOC     (Imem),
    .OMEM_LOC     (Omem),
    .TIMEOUT      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .cur_layer (cur_layer),
    .cur_ts    (cur_ts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses and accepted commands.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (cmd_valid && cmd_ready) xfer_cnt <= xfer_cnt + 1;
  end

  function automatic logic [32:0] pkt(input logic [4:0] dest, input logic [2:0] op,
                                      input logic [7:0] layer, input logic [11:0] ts);
    return {dest, Sched, op, layer, ts};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic respond(input logic [2:0] op, input logic [7:0] layer, input logic [11:0] ts);
    resp_valid = 1'b1;
    resp_data  = {Omem, Sched, op, layer, ts};
    step();
    resp_valid = 1'b0;
    resp_data  = '0;
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (!cmd_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, cmd_valid, 1'b1);
  endtask

  logic [32:0] exp_cmd [10];
  logic [32:0] e;
  int          xb;
  int          db;

  initial begin
    exp_cmd[0] = pkt(Wmem, 3'd0, 8'd0, 12'd0);
    exp_cmd[1] = pkt(Imem, 3'd1, 8'd0, 12'd0);
    exp_cmd[2] = pkt(Omem, 3'd2, 8'd0, 12'd0);
    exp_cmd[3] = pkt(Imem, 3'd1, 8'd0, 12'd1);
    exp_cmd[4] = pkt(Omem, 3'd2, 8'd0, 12'd1);
    exp_cmd[5] = pkt(Wmem, 3'd0, 8'd1, 12'd0);
    exp_cmd[6] = pkt(Imem, 3'd1, 8'd1, 12'd0);
    exp_cmd[7] = pkt(Omem, 3'd2, 8'd1, 12'd0);
    exp_cmd[8] = pkt(Imem, 3'd1, 8'd1, 12'd1);
    exp_cmd[9] = pkt(Omem, 3'd2, 8'd1, 12'd1);

    rst        = 1'b1;
    start      = 1'b0;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    step();
    step();

    // Reset values.
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_cmd_data", cmd_data, 33'd0);
    chk("rst_layer", cur_layer, 8'd0);
    chk("rst_ts", cur_ts, 12'd0);
    chk("rst_resp_ready", resp_ready, 1'b0);
    rst = 1'b0;
    step();
    chk("resp_ready", resp_ready, 1'b1);

    // Full inference, ideal responder: 10 commands then one done pulse.
    cmd_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      wait_cmd("seq_valid");
      chk("seq_data", cmd_data, exp_cmd[i]);
      step();
      chk("seq_valid_drop", cmd_valid, 1'b0);
      e = exp_cmd[i];
      respond(e[22:20] + 3'd4, e[19:12], e[11:0]);
    end
    chk("fin_done", done, 1'b1);
    chk("fin_busy", busy, 1'b0);
    step();
    chk("fin_done_pulse", done, 1'b0);
    chk("fin_busy_after", busy, 1'b0);
    chk("fin_layer_hold", cur_layer, 8'd1);
    chk("fin_ts_hold", cur_ts, 12'd1);
    chk("fin_done_cnt", done_cnt, 1);
    chk("fin_xfer_cnt", xfer_cnt, 10);

    // Backpressure on LOAD_I: data held, one transfer.
    cmd_ready = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("bp_w_data", cmd_data, pkt(Wmem, 3'd0, 8'd0, 12'd0));
    chk("bp_layer_reset", cur_layer, 8'd0);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    respond(3'd4, 8'd0, 12'd0);
    xb = xfer_cnt;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_hold", cmd_valid, 1'b1);
      chk("bp_data_hold", cmd_data, pkt(Imem, 3'd1, 8'd0, 12'd0));
      step();
    end
    cmd_ready = 1'b1;
    step();
    chk("bp_valid_drop", cmd_valid, 1'b0);
    chk("bp_one_xfer", xfer_cnt, xb + 1);

    // Stale/foreign responses in WAIT_TS are dropped; start while busy ignored.
    respond(3'd5, 8'd0, 12'd0);
    chk("go_data", cmd_data, pkt(Omem, 3'd2, 8'd0, 12'd0));
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_ign", cmd_valid, 1'b0);
    chk("busy_start_busy", busy, 1'b1);
    respond(3'd6, 8'd0, 12'd1);
    chk("drop_ts_valid", cmd_valid, 1'b0);
    chk("drop_ts_cur", cur_ts, 12'd0);
    respond(3'd4, 8'd0, 12'd0);
    chk("drop_w_valid", cmd_valid, 1'b0);
    respond(3'd6, 8'd0, 12'd0);
    chk("adv_valid", cmd_valid, 1'b1);
    chk("adv_ts", cur_ts, 12'd1);
    chk("adv_data", cmd_data, pkt(Imem, 3'd1, 8'd0, 12'd1));

    // Reset in WAIT_I aborts without done; restart replays LOAD_W layer 0.
    step();
    chk("wi_busy", busy, 1'b1);
    db  = done_cnt;
    rst = 1'b1;
    step();
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", cmd_valid, 1'b0);
    chk("abort_ts", cur_ts, 12'd0);
    chk("abort_done", done, 1'b0);
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("replay_valid", cmd_valid, 1'b1);
    chk("replay_data", cmd_data, pkt(Wmem, 3'd0, 8'd0, 12'd0));
    chk("abort_no_done", done_cnt, db);

    // Timeout in WAIT_W with no responder.
    step();
`ifdef SCHED_TIMEOUT_EN
    repeat (7) step();
    chk("to_err_pre", err, 1'b0);
    chk("to_busy_pre", busy, 1'b1);
    step();
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_done", done, 1'b0);
    step();
    chk("to_err_sticky", err, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_err_clear", err, 1'b0);
    chk("to_restart_busy", busy, 1'b1);
`else
    repeat (30) step();
    chk("nto_err", err, 1'b0);
    chk("nto_busy", busy, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
